// File: rtl/imem_port_arbiter.sv
// Shares one memory port between debug, load/store and fetch with one outstanding
// transaction, fixed priority, a fetch starvation guard and stale-fetch dropping.
module imem_port_arbiter #(
   parameter int AddrW    = 32,
   parameter int DataW    = 32,
   parameter int StallMax = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               dbg_req_i,
   input  logic [AddrW-1:0]   dbg_addr_i,
   input  logic               dbg_we_i,
   input  logic [DataW/8-1:0] dbg_be_i,
   input  logic [DataW-1:0]   dbg_wdata_i,
   output logic               dbg_gnt_o,
   output logic               dbg_rvalid_o,
   output logic [DataW-1:0]   dbg_rdata_o,
   input  logic               dat_req_i,
   input  logic [AddrW-1:0]   dat_addr_i,
   input  logic               dat_we_i,
   input  logic [DataW/8-1:0] dat_be_i,
   input  logic [DataW-1:0]   dat_wdata_i,
   output logic               dat_gnt_o,
   output logic               dat_rvalid_o,
   output logic [DataW-1:0]   dat_rdata_o,
   input  logic               if_req_i,
   input  logic [AddrW-1:0]   if_addr_i,
   output logic               if_gnt_o,
   output logic               if_rvalid_o,
   output logic [DataW-1:0]   if_rdata_o,
   input  logic               if_flush_i,
   output logic               mem_req_o,
   output logic [AddrW-1:0]   mem_addr_o,
   output logic               mem_we_o,
   output logic [DataW/8-1:0] mem_be_o,
   output logic [DataW-1:0]   mem_wdata_o,
   input  logic               mem_gnt_i,
   input  logic               mem_rvalid_i,
   input  logic [DataW-1:0]   mem_rdata_i
);

   localparam int BeW = DataW / 8;
   localparam logic [3:0] StallLim = 4'(StallMax);

   typedef enum logic [1:0] {IDLE, HOLD, RSP} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_DAT, OWN_IF} owner_t;

   state_t state, state_next;
   owner_t owner, owner_next, winner, grant_to, rsp_to;
   logic stale, stale_next, stale_now;
   logic [3:0] starve_cnt, starve_next;
   logic arb, if_ok, capture;

   logic [AddrW-1:0] win_addr, hold_addr;
   logic             win_we, hold_we;
   logic [BeW-1:0]   win_be, hold_be;
   logic [DataW-1:0] win_wdata, hold_wdata;

   logic unused_bits;
   assign unused_bits = ^if_addr_i[1:0];

   assign dbg_rdata_o = mem_rdata_i;
   assign dat_rdata_o = mem_rdata_i;
   assign if_rdata_o  = mem_rdata_i;

   // A flush in the same cycle already makes the fetch in flight stale.
   assign stale_now = stale || (if_flush_i && owner == OWN_IF && state != IDLE);

   always_comb begin
      arb   = (state == IDLE) || (state == RSP && mem_rvalid_i);
      if_ok = if_req_i && !if_flush_i;
      winner = OWN_NONE;
      if (if_ok && starve_cnt == StallLim) winner = OWN_IF;
      else if (dbg_req_i)                  winner = OWN_DBG;
      else if (dat_req_i)                  winner = OWN_DAT;
      else if (if_ok)                      winner = OWN_IF;

      win_addr  = '0;
      win_we    = 1'b0;
      win_be    = '0;
      win_wdata = '0;
      case (winner)
         OWN_DBG: begin
            win_addr  = dbg_addr_i;
            win_we    = dbg_we_i;
            win_be    = dbg_be_i;
            win_wdata = dbg_wdata_i;
         end
         OWN_DAT: begin
            win_addr  = dat_addr_i;
            win_we    = dat_we_i;
            win_be    = dat_be_i;
            win_wdata = dat_wdata_i;
         end
         OWN_IF: begin
            win_addr = {if_addr_i[AddrW-1:2], 2'b00};
            win_be   = '1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next  = state;
      owner_next  = owner;
      stale_next  = stale_now;
      capture     = 1'b0;
      grant_to    = OWN_NONE;
      rsp_to      = OWN_NONE;
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;

      if (state == RSP && mem_rvalid_i && !(owner == OWN_IF && stale_now))
         rsp_to = owner;

      if (arb) begin
         stale_next = 1'b0;
         owner_next = winner;
         if (winner != OWN_NONE) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = win_addr;
            mem_we_o    = win_we;
            mem_be_o    = win_be;
            mem_wdata_o = win_wdata;
            if (mem_gnt_i) begin
               grant_to   = winner;
               state_next = RSP;
            end else begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end else begin
            state_next = IDLE;
         end
      end else if (state == HOLD) begin
         mem_req_o   = 1'b1;
         mem_addr_o  = hold_addr;
         mem_we_o    = hold_we;
         mem_be_o    = hold_be;
         mem_wdata_o = hold_wdata;
         if (mem_gnt_i) begin
            state_next = RSP;
            if (!(owner == OWN_IF && stale_now)) grant_to = owner;
         end
      end

      dbg_gnt_o    = (grant_to == OWN_DBG);
      dat_gnt_o    = (grant_to == OWN_DAT);
      if_gnt_o     = (grant_to == OWN_IF);
      dbg_rvalid_o = (rsp_to == OWN_DBG);
      dat_rvalid_o = (rsp_to == OWN_DAT);
      if_rvalid_o  = (rsp_to == OWN_IF);
   end

   always_comb begin
      starve_next = starve_cnt;
      if (!if_req_i || if_gnt_o)             starve_next = 4'd0;
      else if (arb && starve_cnt < StallLim) starve_next = starve_cnt + 4'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         owner      <= OWN_NONE;
         stale      <= 1'b0;
         starve_cnt <= 4'd0;
         hold_addr  <= '0;
         hold_we    <= 1'b0;
         hold_be    <= '0;
         hold_wdata <= '0;
      end else begin
         state      <= state_next;
         owner      <= owner_next;
         stale      <= stale_next;
         starve_cnt <= starve_next;
         if (capture) begin
            hold_addr  <= win_addr;
            hold_we    <= win_we;
            hold_be    <= win_be;
            hold_wdata <= win_wdata;
         end
      end
   end

   // A response with nothing outstanding, or stale for a non-fetch owner, is a protocol error.
   unexpected_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
      mem_rvalid_i |-> (state != IDLE && !(stale && owner != OWN_IF)));

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: contention, starvation, lock, alignment,
// flush and mid-transaction reset, checked cycle by cycle.
module tb_imem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        dbg_req_i = 1'b0, dat_req_i = 1'b0, if_req_i = 1'b0;
   logic [31:0] dbg_addr_i = '0, dat_addr_i = '0, if_addr_i = '0;
   logic        dbg_we_i = 1'b0, dat_we_i = 1'b0;
   logic [3:0]  dbg_be_i = '0, dat_be_i = '0;
   logic [31:0] dbg_wdata_i = '0, dat_wdata_i = '0;
   logic        dbg_gnt_o, dat_gnt_o, if_gnt_o;
   logic        dbg_rvalid_o, dat_rvalid_o, if_rvalid_o;
   logic [31:0] dbg_rdata_o, dat_rdata_o, if_rdata_o;
   logic        if_flush_i = 1'b0;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int total = 0;
   int bad   = 0;

   imem_port_arbiter #(.AddrW(32), .DataW(32), .StallMax(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_we_i(dbg_we_i),
      .dbg_be_i(dbg_be_i), .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o),
      .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
      .dat_req_i(dat_req_i), .dat_addr_i(dat_addr_i), .dat_we_i(dat_we_i),
      .dat_be_i(dat_be_i), .dat_wdata_i(dat_wdata_i), .dat_gnt_o(dat_gnt_o),
      .dat_rvalid_o(dat_rvalid_o), .dat_rdata_o(dat_rdata_o),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_flush_i(if_flush_i),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drives one cycle's control inputs just after the edge; checks follow at +2.
   task automatic applyStimulus(input logic rst, input logic dbg, input logic dat,
                                input logic fetch, input logic flush, input logic gnt,
                                input logic rv, input logic [31:0] rdata);
      @(posedge clk_i);
      #1;
      rst_i        = rst;
      dbg_req_i    = dbg;
      dat_req_i    = dat;
      if_req_i     = fetch;
      if_flush_i   = flush;
      mem_gnt_i    = gnt;
      mem_rvalid_i = rv;
      mem_rdata_i  = rdata;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checkOutput(tag, {31'd0, observed}, {31'd0, expected});
   endtask

   task automatic checkGrants(input string tag, input logic dbg, input logic dat,
                              input logic fetch);
      checkBit({tag, ".dbg_gnt"}, dbg_gnt_o, dbg);
      checkBit({tag, ".dat_gnt"}, dat_gnt_o, dat);
      checkBit({tag, ".if_gnt"}, if_gnt_o, fetch);
   endtask

   task automatic checkRvalids(input string tag, input logic dbg, input logic dat,
                               input logic fetch);
      checkBit({tag, ".dbg_rvalid"}, dbg_rvalid_o, dbg);
      checkBit({tag, ".dat_rvalid"}, dat_rvalid_o, dat);
      checkBit({tag, ".if_rvalid"}, if_rvalid_o, fetch);
   endtask

   initial begin
      // reset state
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkBit("rst.mem_req", mem_req_o, 1'b0);
      checkGrants("rst", 0, 0, 0);
      checkRvalids("rst", 0, 0, 0);
      checkOutput("rst.starve", {28'd0, dut.starve_cnt}, 32'd0);

      // contention: dbg, then dat, then fetch, responses one cycle behind
      dbg_addr_i = 32'h10; dat_addr_i = 32'h20; if_addr_i = 32'h30;
      applyStimulus(0, 1, 1, 1, 0, 1, 0, 0);
      checkGrants("cont0", 1, 0, 0);
      checkOutput("cont0.addr", mem_addr_o, 32'h10);
      applyStimulus(0, 0, 1, 1, 0, 1, 1, 32'h1111);
      checkGrants("cont1", 0, 1, 0);
      checkRvalids("cont1", 1, 0, 0);
      checkOutput("cont1.dbg_rdata", dbg_rdata_o, 32'h1111);
      checkOutput("cont1.addr", mem_addr_o, 32'h20);
      applyStimulus(0, 0, 0, 1, 0, 1, 1, 32'h2222);
      checkGrants("cont2", 0, 0, 1);
      checkRvalids("cont2", 0, 1, 0);
      checkOutput("cont2.addr", mem_addr_o, 32'h30);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h3333);
      checkRvalids("cont3", 0, 0, 1);
      checkOutput("cont3.if_rdata", if_rdata_o, 32'h3333);
      checkBit("cont3.mem_req", mem_req_o, 1'b0);

      // starvation: dat hogs the port until fetch has been denied four times
      dat_addr_i = 32'h50; if_addr_i = 32'h60;
      applyStimulus(0, 0, 1, 1, 0, 1, 0, 0);
      checkGrants("starve0", 0, 1, 0);
      for (int i = 1; i < 4; i++) begin
         applyStimulus(0, 0, 1, 1, 0, 1, 1, 32'(i));
         checkGrants("starveN", 0, 1, 0);
         checkBit("starveN.dat_rvalid", dat_rvalid_o, 1'b1);
      end
      applyStimulus(0, 0, 1, 1, 0, 1, 1, 0);
      checkOutput("starve4.cnt", {28'd0, dut.starve_cnt}, 32'd4);
      checkGrants("starve4", 0, 0, 1);
      checkOutput("starve4.addr", mem_addr_o, 32'h60);
      applyStimulus(0, 0, 1, 0, 0, 1, 1, 0);
      checkOutput("starve5.cnt", {28'd0, dut.starve_cnt}, 32'd0);
      checkRvalids("starve5", 0, 0, 1);
      checkGrants("starve5", 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
      checkRvalids("starve6", 0, 1, 0);
      checkBit("starve6.mem_req", mem_req_o, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

      // lock: fetch payload held through three denied cycles despite debug arriving
      if_addr_i = 32'h104; dbg_addr_i = 32'h40;
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      checkBit("lock0.mem_req", mem_req_o, 1'b1);
      checkOutput("lock0.addr", mem_addr_o, 32'h104);
      checkGrants("lock0", 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
      checkOutput("lock1.addr", mem_addr_o, 32'h104);
      checkGrants("lock1", 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
      checkOutput("lock2.addr", mem_addr_o, 32'h104);
      applyStimulus(0, 1, 0, 1, 0, 1, 0, 0);
      checkGrants("lock3", 0, 0, 1);
      checkOutput("lock3.addr", mem_addr_o, 32'h104);
      applyStimulus(0, 1, 0, 0, 0, 1, 1, 32'h55);
      checkRvalids("lock4", 0, 0, 1);
      checkGrants("lock4", 1, 0, 0);
      checkOutput("lock4.addr", mem_addr_o, 32'h40);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h66);
      checkRvalids("lock5", 1, 0, 0);

      // alignment: unaligned fetch presented word-aligned, read-only, all lanes
      if_addr_i = 32'h106; dat_we_i = 1'b1; dat_be_i = 4'h0;
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 0);
      checkOutput("align.addr", mem_addr_o, 32'h104);
      checkOutput("align.be", {28'd0, mem_be_o}, 32'hF);
      checkBit("align.we", mem_we_o, 1'b0);
      checkBit("align.if_gnt", if_gnt_o, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h77);
      checkRvalids("align.rsp", 0, 0, 1);

      // flush in RSP drops the response; the next fetch completes normally
      if_addr_i = 32'h200;
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 0);
      checkBit("flush0.if_gnt", if_gnt_o, 1'b1);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
      checkBit("flush1.if_rvalid", if_rvalid_o, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF);
      checkBit("flush2.if_rvalid", if_rvalid_o, 1'b0);
      if_addr_i = 32'h300;
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 0);
      checkBit("flush3.if_gnt", if_gnt_o, 1'b1);
      checkOutput("flush3.addr", mem_addr_o, 32'h300);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h12345678);
      checkBit("flush4.if_rvalid", if_rvalid_o, 1'b1);
      checkOutput("flush4.if_rdata", if_rdata_o, 32'h12345678);

      // flush coinciding with the fetch response also drops it
      if_addr_i = 32'h400;
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 0);
      checkBit("flushrv0.if_gnt", if_gnt_o, 1'b1);
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 32'hCAFE);
      checkBit("flushrv1.if_rvalid", if_rvalid_o, 1'b0);

      // fetch request during a flush is held off for that cycle
      if_addr_i = 32'h500;
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 0);
      checkBit("flushreq0.if_gnt", if_gnt_o, 1'b0);
      checkBit("flushreq0.mem_req", mem_req_o, 1'b0);
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 0);
      checkBit("flushreq1.if_gnt", if_gnt_o, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h88);
      checkBit("flushreq2.if_rvalid", if_rvalid_o, 1'b1);

      // reset mid-RSP discards the data write's response
      dat_addr_i = 32'h80; dat_we_i = 1'b1; dat_be_i = 4'h3; dat_wdata_i = 32'hAB;
      applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
      checkBit("rspRst0.dat_gnt", dat_gnt_o, 1'b1);
      checkBit("rspRst0.we", mem_we_o, 1'b1);
      checkOutput("rspRst0.be", {28'd0, mem_be_o}, 32'h3);
      checkOutput("rspRst0.wdata", mem_wdata_o, 32'hAB);
      checkOutput("rspRst0.addr", mem_addr_o, 32'h80);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 32'hBAD);
      checkRvalids("rspRst2", 0, 0, 0);
      checkGrants("rspRst2", 0, 0, 0);
      checkBit("rspRst2.mem_req", mem_req_o, 1'b0);
      dat_addr_i = 32'h84; dat_we_i = 1'b0;
      applyStimulus(0, 0, 1, 0, 0, 1, 0, 0);
      checkBit("rspRst3.dat_gnt", dat_gnt_o, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h99);
      checkRvalids("rspRst4", 0, 1, 0);
      checkOutput("rspRst4.dat_rdata", dat_rdata_o, 32'h99);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single instruction/data memory port between three masters: the debug module (`dbg_*`), the load/store unit (`dat_*`) and instruction fetch (`if_*`). It sits between the core and the on-chip memory and enforces one outstanding transaction. Priority is fixed, with a starvation guard for fetch. It drops fetch responses made stale by a jump flush.

## Interface
Parameters:
- `AddrW`, 32, address width
- `DataW`, 32, data width; byte enables are `DataW/8`
- `StallMax`, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports (reset is synchronous, active-high):
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous active-high reset
- `dbg_req_i`, `dat_req_i`, `if_req_i`  in  1  master request; held until the matching gnt
- `dbg_addr_i`, `dat_addr_i`, `if_addr_i`  in  AddrW  byte address
- `dbg_we_i`, `dat_we_i`  in  1  write enable; fetch is read-only
- `dbg_be_i`, `dat_be_i`  in  DataW/8  byte enables
- `dbg_wdata_i`, `dat_wdata_i`  in  DataW  write data
- `dbg_gnt_o`, `dat_gnt_o`, `if_gnt_o`  out  1  request accepted by memory
- `dbg_rvalid_o`, `dat_rvalid_o`, `if_rvalid_o`  out  1  response for that master; also acks writes
- `dbg_rdata_o`, `dat_rdata_o`, `if_rdata_o`  out  DataW  equal to `mem_rdata_i`; meaningful only with rvalid
- `if_flush_i`  in  1  jump/flush from the core; makes any fetch in flight stale
- `mem_req_o`  out  1  request to memory
- `mem_addr_o`  out  AddrW  memory address
- `mem_we_o`  out  1  write enable to memory
- `mem_be_o`  out  DataW/8  byte enables to memory
- `mem_wdata_o`  out  DataW  write data to memory
- `mem_gnt_i`  in  1  memory accepts the presented request
- `mem_rvalid_i`  in  1  memory response valid (≥1 cycle after gnt)
- `mem_rdata_i`  in  DataW  memory read data

## Operation
- States: IDLE, HOLD (request presented, not yet granted, payload locked), RSP (granted, awaiting `mem_rvalid_i`).
- Arbitration runs in IDLE. It also runs in RSP in the same cycle that `mem_rvalid_i`=1, which allows back-to-back transactions.
- Arbitration order:
  - If `starve_cnt`==StallMax and `if_req_i`=1, fetch wins.
  - Otherwise debug > data > fetch.
- The winner drives `mem_*` combinationally.
- Fetch address is forced word-aligned: `{if_addr_i[AddrW-1:2],2'b00}`. `mem_we_o`=0 and `mem_be_o`=all-ones for fetch.
- If `mem_gnt_i`=1 in the arbitration cycle:
  - The winner's gnt is asserted in the same cycle.
  - Go to RSP and register `owner`.
- If `mem_gnt_i`=0:
  - Register the winner's payload and `owner`, then go to HOLD.
  - In HOLD, `mem_*` is driven from the registered payload. No re-arbitration takes place, even if a higher-priority request arrives.
- HOLD with `mem_gnt_i`=1:
  - Assert the owner's gnt, unless the owner is fetch and it is stale.
  - Go to RSP.
- RSP: `mem_req_o`=0 except for the back-to-back issue cycle. When `mem_rvalid_i`=1, pulse the owner's rvalid, unless it is a stale fetch.
- Stale flag:
  - Set when `if_flush_i`=1 and owner is fetch in HOLD or RSP.
  - Cleared when that transaction's response returns.
  - A stale fetch still completes on the memory side. Its gnt (in HOLD) and rvalid are suppressed.
- `starve_cnt` (4 bits):
  - Increments, saturating at StallMax, each arbitration cycle in which `if_req_i`=1 and fetch is not granted.
  - Cleared on a fetch gnt or when `if_req_i`=0.
- A fetch request presented while `if_flush_i`=1 is not granted in that cycle.

## Timing
- Reset values:
  - state IDLE, `owner`=none, stale 0, `starve_cnt` 0.
  - All gnt and rvalid outputs 0; `mem_req_o` 0.
  - Registered payload 0.
- Grant latency: 0 cycles from request when memory is ready in IDLE.
- Peak throughput: one transaction per cycle with a 1-cycle memory.
- Response routing: rvalid is combinational from `mem_rvalid_i`, gated by `owner` and stale.
- `mem_rvalid_i` in IDLE, or while stale for a non-fetch owner, is ignored. An assertion flags it as an error.
- Reset asserted mid-transaction: return to IDLE next edge; the in-flight response is discarded.
- Simultaneous `if_flush_i` and fetch `mem_rvalid_i` in RSP: the response is dropped (`if_rvalid_o`=0).

## Test plan
- Contention: all three requests in the same cycle, memory always ready, 1-cycle latency -> grants are dbg in cycle 0, dat in cycle 1, if in cycle 2; each rvalid follows its gnt by one cycle.
- Starvation: `dat_req_i` held high, `if_req_i` high, StallMax=4 -> fetch is granted at the 5th arbitration cycle; `starve_cnt` returns to 0.
- Lock: `mem_gnt_i`=0 for 3 cycles while fetch addr 0x104 is held; `dbg_req_i` rises in cycle 1 -> `mem_addr_o` stays 0x104; the fetch gnt comes first, then the debug gnt.
- Alignment: fetch addr 0x0000_0106 -> `mem_addr_o`=0x0000_0104, `mem_be_o`=4'hF, `mem_we_o`=0.
- Flush: fetch granted at 0x200; `if_flush_i` pulsed in RSP; response 0xDEAD_BEEF returns -> `if_rvalid_o` stays 0; the next fetch at 0x300 gets `if_rvalid_o`=1 normally.
- Reset mid-RSP: `rst_i` asserted after a data gnt -> all outputs 0 next cycle; a late `mem_rvalid_i` produces no rvalid.
